bus_arbiter: RTL and testbench

Two-requester arbiter that shares the daisy-chained 16-bit register bus (addr/wdata/rdata/rw/valid) between two bus masters, e.g. the host bridge and an on-chip sequencer. Grants one requester at a time round-robin, drives a single transaction into the head of the core chain, and waits for it to return at the chain tail. Routes the returned rdata back to the owner, or signals an error on timeout. Exactly one transaction is outstanding on the chain at any time.

---
 rtl/bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Purpose: two-requester round-robin arbiter sharing one daisy-chained 16-bit register bus, one transaction in flight.
// Latency: handshake at T, chain head valid at T+1, response pulse at T+2+L (chain latency L); timeout response at T+3+TIMEOUT.
// Backpressure: ready is combinational and only asserted in IDLE; a requester holds valid and payload until it sees ready.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    // Requester 0
    input  logic [15:0] r0_addr_i,
    input  logic [15:0] r0_wdata_i,
    input  logic        r0_rw_i,
    input  logic        r0_valid_i,
    output logic        r0_ready_o,
    output logic [15:0] r0_rdata_o,
    output logic        r0_rvalid_o,
    output logic        r0_err_o,

    // Requester 1
    input  logic [15:0] r1_addr_i,
    input  logic [15:0] r1_wdata_i,
    input  logic        r1_rw_i,
    input  logic        r1_valid_i,
    output logic        r1_ready_o,
    output logic [15:0] r1_rdata_o,
    output logic        r1_rvalid_o,
    output logic        r1_err_o,

    // Chain head
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,

    // Chain tail
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;

    // Arbitration history: 1 means requester 1 was granted last, so r0 wins the first tie.
    logic        r_last_grant;
    // Which requester owns the transaction currently on the chain.
    logic        r_owner;
    logic [15:0] r_count;

    // Chain head registers
    logic [15:0] r_addr_o;
    logic [15:0] r_wdata_o;
    logic [15:0] r_rdata_o;
    logic        r_rw_o;
    logic        r_valid_o;

    // Per-requester response registers
    logic [15:0] r_r0_rdata;
    logic        r_r0_rvalid;
    logic        r_r0_err;
    logic [15:0] r_r1_rdata;
    logic        r_r1_rvalid;
    logic        r_r1_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_hs;
    logic [15:0] w_req_addr;
    logic [15:0] w_req_wdata;
    logic        w_req_rw;
    logic        w_rsp_ok;
    logic        w_rsp_to;
    logic        w_rsp;
    logic [15:0] w_rsp_data;

    // The returned address/write data/direction are not checked; only valid and rdata matter.
    logic        w_unused;
    assign w_unused = ^{addr_i, wdata_i, rw_i};

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if ((r_state == ST_IDLE) && !rst) begin
            if (r0_valid_i && r1_valid_i) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = r0_valid_i;
                w_gnt1 = r1_valid_i;
            end
        end
    end

    // A grant is only ever given to a requester with valid high, so a grant is a handshake.
    assign w_hs        = w_gnt0 | w_gnt1;
    assign w_req_addr  = w_gnt1 ? r1_addr_i  : r0_addr_i;
    assign w_req_wdata = w_gnt1 ? r1_wdata_i : r0_wdata_i;
    assign w_req_rw    = w_gnt1 ? r1_rw_i    : r0_rw_i;

    // Next-state logic; returns arriving outside WAIT are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_ok    = 1'b0;
        w_rsp_to    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (valid_i) begin
                    w_rsp_ok    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_count == TIMEOUT_C) begin
                    w_rsp_to    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rsp      = w_rsp_ok | w_rsp_to;
    assign w_rsp_data = w_rsp_ok ? rdata_i : 16'h0000;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted request onto the chain head; valid_o is high for the ISSUE cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_addr_o     <= 16'h0000;
            r_wdata_o    <= 16'h0000;
            r_rdata_o    <= 16'h0000;
            r_rw_o       <= 1'b0;
            r_valid_o    <= 1'b0;
        end else if (w_hs) begin
            r_last_grant <= w_gnt1;
            r_owner      <= w_gnt1;
            r_addr_o     <= w_req_addr;
            r_wdata_o    <= w_req_wdata;
            r_rdata_o    <= 16'h0000;
            r_rw_o       <= w_req_rw;
            r_valid_o    <= 1'b1;
        end else begin
            r_valid_o    <= 1'b0;
        end
    end

    // WAIT cycle counter: cleared leaving ISSUE, advanced while no return and not yet expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'h0000;
        end else if (r_state == ST_ISSUE) begin
            r_count <= 16'h0000;
        end else if ((r_state == ST_WAIT) && !w_rsp) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Route the response (data or timeout) to the owner as a one-cycle pulse; rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r0_rdata  <= 16'h0000;
            r_r0_rvalid <= 1'b0;
            r_r0_err    <= 1'b0;
            r_r1_rdata  <= 16'h0000;
            r_r1_rvalid <= 1'b0;
            r_r1_err    <= 1'b0;
        end else begin
            r_r0_rvalid <= w_rsp && !r_owner;
            r_r0_err    <= w_rsp_to && !r_owner;
            r_r1_rvalid <= w_rsp && r_owner;
            r_r1_err    <= w_rsp_to && r_owner;
            if (w_rsp && !r_owner) begin
                r_r0_rdata <= w_rsp_data;
            end
            if (w_rsp && r_owner) begin
                r_r1_rdata <= w_rsp_data;
            end
        end
    end

    assign r0_ready_o  = w_gnt0;
    assign r1_ready_o  = w_gnt1;
    assign r0_rdata_o  = r_r0_rdata;
    assign r0_rvalid_o = r_r0_rvalid;
    assign r0_err_o    = r_r0_err;
    assign r1_rdata_o  = r_r1_rdata;
    assign r1_rvalid_o = r_r1_rvalid;
    assign r1_err_o    = r_r1_err;

    assign addr_o      = r_addr_o;
    assign wdata_o     = r_wdata_o;
    assign rdata_o     = r_rdata_o;
    assign rw_o        = r_rw_o;
    assign valid_o     = r_valid_o;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a 2-cycle chain model with a small register file sits on the chain.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or 1 unit later (ready).
// The chain model moves on the falling edge so a valid_o seen in cycle C returns as valid_i in cycle C+2.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r0_addr_i, r0_wdata_i, r1_addr_i, r1_wdata_i;
    logic        r0_rw_i, r0_valid_i, r1_rw_i, r1_valid_i;
    logic        r0_ready_o, r0_rvalid_o, r0_err_o, r1_ready_o, r1_rvalid_o, r1_err_o;
    logic [15:0] r0_rdata_o, r1_rdata_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i), .r0_rw_i(r0_rw_i), .r0_valid_i(r0_valid_i),
        .r0_ready_o(r0_ready_o), .r0_rdata_o(r0_rdata_o), .r0_rvalid_o(r0_rvalid_o), .r0_err_o(r0_err_o),
        .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i), .r1_rw_i(r1_rw_i), .r1_valid_i(r1_valid_i),
        .r1_ready_o(r1_ready_o), .r1_rdata_o(r1_rdata_o), .r1_rvalid_o(r1_rvalid_o), .r1_err_o(r1_err_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i)
    );

    // Chain model: L=2, register file, optional drop of all transactions, optional stray return.
    typedef struct packed {
        logic        v;
        logic        rw;
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] d;
    } beat_t;

    beat_t       s1 = '0;
    beat_t       s2 = '0;
    beat_t       s3 = '0;
    logic [15:0] mem [16] = '{3: 16'hBEEF, default: 16'h0000};
    logic        chain_drop = 1'b0;
    logic        inject = 1'b0;

    always @(negedge clk) begin
        s3 = s2;
        s2 = s1;
        s1 = '0;
        if (valid_o && !chain_drop) begin
            s1.v  = 1'b1;
            s1.rw = rw_o;
            s1.a  = addr_o;
            s1.w  = wdata_o;
            if (rw_o) begin
                mem[addr_o[3:0]] = wdata_o;
                s1.d = 16'hA5A5;
            end else begin
                s1.d = mem[addr_o[3:0]];
            end
        end
        valid_i = s3.v | inject;
        rdata_i = inject ? 16'hDEAD : s3.d;
        addr_i  = s3.a;
        wdata_i = s3.w;
        rw_i    = s3.rw;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] w, input logic rw);
        if (id == 0) begin
            r0_valid_i = v; r0_addr_i = a; r0_wdata_i = w; r0_rw_i = rw;
        end else begin
            r1_valid_i = v; r1_addr_i = a; r1_wdata_i = w; r1_rw_i = rw;
        end
    endtask

    // Present a request until it is accepted; returns in cycle T+1 with valid dropped.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] w, input logic rw, output bit ok);
        ok = 1'b0;
        set_req(id, 1'b1, a, w, rw);
        for (int k = 0; k < 40; k++) begin
            #1;
            if ((id == 0 && r0_ready_o) || (id == 1 && r1_ready_o)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        set_req(id, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    // Advance from cycle T+start until the owner's rvalid; lat is the cycle offset from T (-1 if none).
    task automatic wait_resp(input int id, input int start, output int lat, output logic [15:0] d,
                             output logic e, output bit other);
        lat = -1; d = 16'hxxxx; e = 1'bx; other = 1'b0;
        for (int c = start + 1; c <= start + 40; c++) begin
            tick();
            if ((id == 0 && r1_rvalid_o) || (id == 1 && r0_rvalid_o)) other = 1'b1;
            if (id == 0 && r0_rvalid_o) begin
                lat = c; d = r0_rdata_o; e = r0_err_o; break;
            end
            if (id == 1 && r1_rvalid_o) begin
                lat = c; d = r1_rdata_o; e = r1_err_o; break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        n_tests++;
        if ({r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o, valid_o, rw_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o, valid_o, rw_o});
        end
        n_tests++;
        if ({r0_rdata_o, r1_rdata_o, addr_o, wdata_o, rdata_o} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {r0_rdata_o, r1_rdata_o, addr_o, wdata_o, rdata_o});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bit ok; int lat; logic [15:0] d; logic e; bit oth;
        issue(0, 16'h0003, 16'h0000, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_read_hs: got no ready want ready"); end
        n_tests++;
        if ({valid_o, rw_o, addr_o, rdata_o} !== {1'b1, 1'b0, 16'h0003, 16'h0000}) begin
            n_fail++;
            $display("FAIL single_read_issue: got v=%b rw=%b a=%h rd=%h want v=1 rw=0 a=0003 rd=0000",
                     valid_o, rw_o, addr_o, rdata_o);
        end
        tick();
        n_tests++;
        if ({valid_o, addr_o} !== {1'b0, 16'h0003}) begin
            n_fail++;
            $display("FAIL single_read_hold: got v=%b a=%h want v=0 a=0003", valid_o, addr_o);
        end
        wait_resp(0, 2, lat, d, e, oth);
        n_tests++;
        if (lat !== 4 || d !== 16'hBEEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_rsp: got lat=%0d d=%h e=%b want lat=4 d=beef e=0", lat, d, e);
        end
        n_tests++;
        if (oth || {r1_rvalid_o, r1_err_o, r1_ready_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_read_r1_quiet: got other=%b r1=%b want 0", oth, {r1_rvalid_o, r1_err_o, r1_ready_o});
        end
        tick();
        n_tests++;
        if (r0_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_pulse: got rvalid=%b want 0", r0_rvalid_o);
        end
    endtask

    task automatic test_write_readback();
        bit ok; int lat; logic [15:0] d; logic e; bit oth;
        issue(1, 16'h0005, 16'h1234, 1'b1, ok);
        wait_resp(1, 1, lat, d, e, oth);
        n_tests++;
        if (!ok || lat !== 4 || e !== 1'b0 || d !== 16'hA5A5 || oth) begin
            n_fail++;
            $display("FAIL write_ack: got ok=%b lat=%0d e=%b d=%h oth=%b want ok=1 lat=4 e=0 d=a5a5 oth=0",
                     ok, lat, e, d, oth);
        end
        issue(1, 16'h0005, 16'h0000, 1'b0, ok);
        wait_resp(1, 1, lat, d, e, oth);
        n_tests++;
        if (!ok || lat !== 4 || e !== 1'b0 || d !== 16'h1234 || oth) begin
            n_fail++;
            $display("FAIL readback: got ok=%b lat=%0d e=%b d=%h oth=%b want ok=1 lat=4 e=0 d=1234 oth=0",
                     ok, lat, e, d, oth);
        end
        tick();
    endtask

    task automatic test_contention();
        int order [4] = '{-1, -1, -1, -1};
        int hs_c  [4] = '{0, 0, 0, 0};
        int ng = 0, nr = 0, misroute = 0, overlap = 0, owner = -1;
        bit outst = 1'b0;
        rst = 1'b1;
        set_req(0, 1'b1, 16'h0003, 16'h0000, 1'b0);
        set_req(1, 1'b1, 16'h0005, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            #1;
            if (r0_rvalid_o || r1_rvalid_o) begin
                if ((r0_rvalid_o && owner != 0) || (r1_rvalid_o && owner != 1) || (r0_rvalid_o && r1_rvalid_o))
                    misroute++;
                outst = 1'b0;
                nr++;
            end
            if (valid_o) begin
                if (outst) overlap++;
                outst = 1'b1;
            end
            if (r0_ready_o && r1_ready_o) overlap++;
            if (ng < 4 && (r0_ready_o || r1_ready_o)) begin
                order[ng] = r1_ready_o ? 1 : 0;
                hs_c[ng]  = c;
                owner     = order[ng];
                ng++;
            end
            tick();
            if (ng == 4) begin
                set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
                set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (order[i] !== (i % 2)) begin
                n_fail++;
                $display("FAIL contention_order[%0d]: got r%0d want r%0d", i, order[i], i % 2);
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (hs_c[i] - hs_c[i-1] !== 4) begin
                n_fail++;
                $display("FAIL contention_spacing[%0d]: got %0d want 4", i, hs_c[i] - hs_c[i-1]);
            end
        end
        n_tests++;
        if (nr !== 4 || misroute !== 0 || overlap !== 0) begin
            n_fail++;
            $display("FAIL contention_route: got rsp=%0d misroute=%0d overlap=%0d want 4 0 0", nr, misroute, overlap);
        end
    endtask

    task automatic test_timeout();
        bit ok; int lat; logic [15:0] d; logic e; bit oth;
        chain_drop = 1'b1;
        issue(0, 16'h0003, 16'h0000, 1'b0, ok);
        wait_resp(0, 1, lat, d, e, oth);
        n_tests++;
        if (!ok || lat !== TO + 3 || e !== 1'b1 || d !== 16'h0000 || oth) begin
            n_fail++;
            $display("FAIL timeout_rsp: got ok=%b lat=%0d e=%b d=%h oth=%b want ok=1 lat=%0d e=1 d=0000 oth=0",
                     ok, lat, e, d, oth, TO + 3);
        end
        chain_drop = 1'b0;
        issue(1, 16'h0003, 16'h0000, 1'b0, ok);
        wait_resp(1, 1, lat, d, e, oth);
        n_tests++;
        if (!ok || lat !== 4 || e !== 1'b0 || d !== 16'hBEEF || oth) begin
            n_fail++;
            $display("FAIL timeout_recover: got ok=%b lat=%0d e=%b d=%h oth=%b want ok=1 lat=4 e=0 d=beef oth=0",
                     ok, lat, e, d, oth);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int lat; logic [15:0] d; logic e; bit oth; int stray = 0;
        issue(0, 16'h0003, 16'h0000, 1'b0, ok);
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o, valid_o, rw_o} !== 8'h00 ||
            {r0_rdata_o, r1_rdata_o, addr_o, wdata_o, rdata_o} !== 80'h0) begin
            n_fail++;
            $display("FAIL midwait_reset: got ctrl=%b data=%h want all 0",
                     {r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o, valid_o, rw_o},
                     {r0_rdata_o, r1_rdata_o, addr_o, wdata_o, rdata_o});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (r0_rvalid_o || r1_rvalid_o) stray++;
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midwait_late_return: got %0d rvalid cycles want 0", stray);
        end
        set_req(0, 1'b1, 16'h0003, 16'h0000, 1'b0);
        set_req(1, 1'b1, 16'h0005, 16'h0000, 1'b0);
        #1;
        n_tests++;
        if ({r0_ready_o, r1_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL midwait_first_grant: got r0/r1 ready=%b want 10", {r0_ready_o, r1_ready_o});
        end
        tick();
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        wait_resp(0, 1, lat, d, e, oth);
        n_tests++;
        if (lat !== 4 || d !== 16'hBEEF || e !== 1'b0 || oth) begin
            n_fail++;
            $display("FAIL midwait_post_read: got lat=%0d d=%h e=%b oth=%b want lat=4 d=beef e=0 oth=0", lat, d, e, oth);
        end
        tick();
    endtask

    task automatic test_stray_return();
        bit ok; int lat; logic [15:0] d; logic e; bit oth; int stray = 0;
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r0_rvalid_o || r1_rvalid_o || r0_err_o || r1_err_o) stray++;
            tick();
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL stray_rsp: got %0d response cycles want 0", stray);
        end
        set_req(1, 1'b1, 16'h0005, 16'h0000, 1'b0);
        #1;
        n_tests++;
        if (r1_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_still_idle: got ready=%b want 1", r1_ready_o);
        end
        tick();
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        wait_resp(1, 1, lat, d, e, oth);
        n_tests++;
        if (lat !== 4 || d !== 16'h1234 || e !== 1'b0 || oth) begin
            n_fail++;
            $display("FAIL stray_post_read: got lat=%0d d=%h e=%b oth=%b want lat=4 d=1234 e=0 oth=0", lat, d, e, oth);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        test_stray_return();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
